clic_dispatch: RTL and testbench

Sequential dispatch controller for the `can_clic` priority arbiter. It owns the pending bits and the running priority threshold, and drives the arbiter inputs. It turns the arbiter's `is_interrupt`/`index` result into a request/acknowledge handshake with the core. On each taken interrupt it pushes the old threshold onto a nesting stack and raises the threshold; on each return it pops the stack and restores the threshold.

---
 rtl/common_pkg.sv | 21 ++
 rtl/clic_prio_stack.sv | 45 ++++
 rtl/clic_dispatch.sv | 116 +++++++++++
 tb/tb_clic_dispatch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared types and sizing for the CLIC dispatch slice.
package common_pkg;
  localparam int unsigned NrEntries    = 4;
  localparam int unsigned PrioWidth    = 3;
  localparam int unsigned IdxWidth     = $clog2(NrEntries);
  localparam int unsigned ThresholdIdx = NrEntries - 1;

  typedef logic [PrioWidth-1:0] Prio;
  typedef Prio [NrEntries-1:0]  PrioEntries;
  typedef logic [NrEntries-1:0] BitEntries;
  typedef logic [IdxWidth-1:0]  Index;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } dispatch_state_e;

  // Masks selecting the threshold slot in the per-source vectors.
  localparam BitEntries  ThrBit      = BitEntries'(1) << ThresholdIdx;
  localparam PrioEntries ThrPrioMask = PrioEntries'({PrioWidth{1'b1}}) << (ThresholdIdx * PrioWidth);
endpackage

// File: rtl/clic_prio_stack.sv
// LIFO of saved thresholds; pop+push in one cycle overwrites the top in place.
module clic_prio_stack
  import common_pkg::*;
#(
  parameter  int unsigned DEPTH = 7,
  localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  Prio           push_data,
  output Prio           top,
  output logic [DW-1:0] depth
);

  Prio           stack_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d, wr_idx;

  always_comb begin
    depth_d = depth_q;
    if (push && !pop)      depth_d = depth_q + DW'(1);
    else if (pop && !push) depth_d = depth_q - DW'(1);
  end

  assign wr_idx = pop ? depth_q - DW'(1) : depth_q;
  assign top    = (depth_q == '0) ? '0 : stack_q[depth_q - DW'(1)];
  assign depth  = depth_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      depth_q <= depth_d;
      if (push) stack_q[wr_idx] <= push_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && depth_q == DW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && depth_q == '0));

endmodule

// File: rtl/clic_dispatch.sv
// Pending/threshold owner for can_clic; converts arbiter result into a req/ack handshake.
module clic_dispatch
  import common_pkg::*;
#(
  parameter  int unsigned STACK_DEPTH = 2**PrioWidth - 1,
  localparam int unsigned DepthW      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  PrioEntries        prio_cfg,
  input  BitEntries         enable_cfg,
  input  BitEntries         pend_set,
  input  logic              arb_is_interrupt,
  input  Index              arb_index,
  output PrioEntries        arb_entries,
  output BitEntries         arb_enable,
  output BitEntries         arb_pend,
  output logic              irq_req,
  output Index              irq_id,
  output Prio               irq_prio,
  input  logic              irq_ack,
  input  logic              irq_ret,
  output Prio               cur_threshold,
  output logic [DepthW-1:0] depth
);

  dispatch_state_e state_q, state_d;
  BitEntries       pend_q, pend_d, clr;
  logic            req_q, req_d;
  Index            id_q, id_d;
  Prio             prio_q, prio_d, thr_q, thr_d;
  Prio             stk_top, push_data;
  logic            push, pop;
  logic [DepthW-1:0] stk_depth;

  clic_prio_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (reset),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .top       (stk_top),
    .depth     (stk_depth)
  );

  assign arb_entries = (prio_cfg & ~ThrPrioMask) | (PrioEntries'(thr_q) << (ThresholdIdx * PrioWidth));
  assign arb_enable  = enable_cfg | ThrBit;
  assign arb_pend    = pend_q | ThrBit;

  assign pop       = irq_ret && (stk_depth != '0);
  // Tail-chain: the popped value goes straight back on, leaving the stack unchanged.
  assign push_data = pop ? stk_top : thr_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    prio_d  = prio_q;
    thr_d   = thr_q;
    clr     = '0;
    push    = 1'b0;
    if (pop) thr_d = stk_top;
    unique case (state_q)
      IDLE: begin
        if (arb_is_interrupt) begin
          id_d    = arb_index;
          prio_d  = prio_cfg[arb_index];
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr[id_q] = 1'b1;
          push      = 1'b1;
          thr_d     = prio_q;
          req_d     = 1'b0;
          state_d   = IDLE;
        end else if (!arb_is_interrupt) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end else begin
          id_d   = arb_index;
          prio_d = prio_cfg[arb_index];
        end
      end
      default: state_d = IDLE;
    endcase
    pend_d = (pend_q & ~clr) | pend_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      req_q   <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      thr_q   <= thr_d;
    end
  end

  assign irq_req       = req_q;
  assign irq_id        = id_q;
  assign irq_prio      = prio_q;
  assign cur_threshold = thr_q;
  assign depth         = stk_depth;

endmodule

// File: tb/tb_clic_dispatch.sv
// Directed bench for clic_dispatch with a behavioural can_clic and a request scoreboard.
module tb_clic_dispatch;
  import common_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  PrioEntries prio_cfg, arb_entries;
  BitEntries  enable_cfg, pend_set, arb_enable, arb_pend;
  logic       arb_is_interrupt;
  Index       arb_index;
  logic       irq_req, irq_ack, irq_ret;
  Index       irq_id;
  Prio        irq_prio, cur_threshold;
  logic [2:0] depth;

  always #5 clk = ~clk;

  clic_dispatch #(.STACK_DEPTH(7)) dut (
    .clk              (clk),
    .reset            (reset),
    .prio_cfg         (prio_cfg),
    .enable_cfg       (enable_cfg),
    .pend_set         (pend_set),
    .arb_is_interrupt (arb_is_interrupt),
    .arb_index        (arb_index),
    .arb_entries      (arb_entries),
    .arb_enable       (arb_enable),
    .arb_pend         (arb_pend),
    .irq_req          (irq_req),
    .irq_id           (irq_id),
    .irq_prio         (irq_prio),
    .irq_ack          (irq_ack),
    .irq_ret          (irq_ret),
    .cur_threshold    (cur_threshold),
    .depth            (depth)
  );

  // Arbiter: highest enabled+pending priority strictly above the threshold slot; lowest index on ties.
  always_comb begin
    Prio best;
    best             = arb_entries[ThresholdIdx];
    arb_index        = Index'(ThresholdIdx);
    arb_is_interrupt = 1'b0;
    for (int i = 0; i < int'(ThresholdIdx); i++) begin
      if (arb_enable[i] && arb_pend[i] && arb_entries[i] > best) begin
        best             = arb_entries[i];
        arb_index        = Index'(i);
        arb_is_interrupt = 1'b1;
      end
    end
  end

  typedef struct {
    int id;
    int prio;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_req = 1'b0;
  Index prev_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input int id, input int prio, input int lat);
    q.push_back('{id, prio, cyc + lat});
  endtask

  // Monitor: a new request (rise, or id change while high) must match the next scoreboard entry.
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (irq_req && (!prev_req || irq_id != prev_id)) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: got id %0d prio %0d expected no request (cycle %0d)",
                   irq_id, irq_prio, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("req_id", 32'(irq_id), mon_e.id);
          chk("req_prio", 32'(irq_prio), mon_e.prio);
          chk("req_cycle", cyc, mon_e.cyc);
        end
      end
      prev_req = irq_req;
      prev_id  = irq_id;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    prio_cfg   = {3'd0, 3'd3, 3'd5, 3'd2};
    enable_cfg = 4'b1111;
    pend_set   = '0;
    irq_ack    = 1'b0;
    irq_ret    = 1'b0;
    step(); step();
    chk("rst_req", irq_req, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_prio", irq_prio, 0);
    chk("rst_thr", cur_threshold, 0);
    chk("rst_depth", depth, 0);
    chk("rst_arb_pend", arb_pend, 4'b1000);
    chk("rst_arb_enable", arb_enable, 4'b1111);
    chk("rst_arb_entries", arb_entries, {3'd0, 3'd3, 3'd5, 3'd2});
    reset = 1'b0;
    step();

    // First request: source 1 at prio 5, two cycles after the set pulse.
    pend_set = 4'b0010; expect_req(1, 5, 2);
    step(); pend_set = '0;
    step();
    chk("s1_req_high", irq_req, 1);
    irq_ack = 1'b1;
    step(); irq_ack = 1'b0;
    chk("ack_thr", cur_threshold, 5);
    chk("ack_depth", depth, 1);
    chk("ack_req_low", irq_req, 0);
    chk("ack_pend", arb_pend, 4'b1000);
    chk("ack_thr_slot", arb_entries[ThresholdIdx], 5);
    pend_set = 4'b0001;
    step(); pend_set = '0;
    step(); step();
    chk("masked_req", irq_req, 0);
    chk("masked_pend", arb_pend, 4'b1001);

    // Return unmasks source 0.
    irq_ret = 1'b1; expect_req(0, 2, 2);
    step(); irq_ret = 1'b0;
    chk("ret_thr", cur_threshold, 0);
    chk("ret_depth", depth, 0);
    step();

    // Preempt while requesting source 0.
    pend_set = 4'b0100; expect_req(2, 3, 2);
    step(); pend_set = '0;
    chk("pre_req_hold1", irq_req, 1);
    step();
    chk("pre_req_hold2", irq_req, 1);
    irq_ack = 1'b1;
    step(); irq_ack = 1'b0;
    chk("pre_ack_pend", arb_pend, 4'b1001);
    chk("pre_ack_thr", cur_threshold, 3);
    chk("pre_ack_depth", depth, 1);
    chk("pre_ack_req", irq_req, 0);

    // Return, then reset in the middle of the resulting request.
    irq_ret = 1'b1; expect_req(0, 2, 2);
    step(); irq_ret = 1'b0;
    chk("ret2_thr", cur_threshold, 0);
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("midrst_req", irq_req, 0);
    chk("midrst_pend", arb_pend, 4'b1000);
    chk("midrst_id", irq_id, 0);
    step(); reset = 1'b0;
    step();

    // Return at depth 0 is ignored.
    irq_ret = 1'b1;
    step(); irq_ret = 1'b0;
    chk("ret0_thr", cur_threshold, 0);
    chk("ret0_depth", depth, 0);
    step();
    chk("ret0_req", irq_req, 0);

    // Tail-chain: depth 1 at threshold 5, then ack prio 6 together with a return.
    prio_cfg[2] = 3'd6;
    pend_set = 4'b0010; expect_req(1, 5, 2);
    step(); pend_set = '0;
    step();
    irq_ack = 1'b1;
    step(); irq_ack = 1'b0;
    chk("tc_pre_thr", cur_threshold, 5);
    chk("tc_pre_depth", depth, 1);
    pend_set = 4'b0100; expect_req(2, 6, 2);
    step(); pend_set = '0;
    step();
    irq_ack = 1'b1; irq_ret = 1'b1;
    step(); irq_ack = 1'b0; irq_ret = 1'b0;
    chk("tc_depth", depth, 1);
    chk("tc_thr", cur_threshold, 6);
    chk("tc_req", irq_req, 0);
    irq_ret = 1'b1;
    step(); irq_ret = 1'b0;
    chk("tc_ret_thr", cur_threshold, 0);
    chk("tc_ret_depth", depth, 0);

    // Set pulse on the same cycle as the ack of that source wins over the clear.
    pend_set = 4'b0010; expect_req(1, 5, 2);
    step(); pend_set = '0;
    step();
    irq_ack = 1'b1; pend_set = 4'b0010;
    step(); irq_ack = 1'b0; pend_set = '0;
    chk("setack_pend", arb_pend, 4'b1010);
    chk("setack_thr", cur_threshold, 5);
    chk("setack_depth", depth, 1);
    step();
    chk("setack_masked", irq_req, 0);
    irq_ret = 1'b1; expect_req(1, 5, 2);
    step(); irq_ret = 1'b0;
    step();
    irq_ack = 1'b1;
    step(); irq_ack = 1'b0;
    chk("final_pend", arb_pend, 4'b1000);
    chk("final_thr", cur_threshold, 5);
    chk("final_depth", depth, 1);
    step(); step();

    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
